// File: rtl/cache_pkg.sv
// Shared definitions for the cache line refill path.
// Contents: address/line geometry constants, the refill FSM state type, and
// helpers that split a line address (byte address without its offset)
// into tag and set index.
package cache_pkg;

    localparam int ADDR_W        = 32;
    localparam int TAG           = 20;
    localparam int INDEX         = 8;
    localparam int OFFSET        = 4;
    localparam int WORD_SIZE_BIT = 32;
    localparam int WORDS         = 4;
    localparam int DATA_BLOCK    = WORDS * WORD_SIZE_BIT;
    localparam int LINE_W        = ADDR_W - OFFSET;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } fill_state_t;

    // line address = {tag, index}
    function automatic logic [TAG-1:0] tag_of(input logic [LINE_W-1:0] line);
        return line[LINE_W-1 -: TAG];
    endfunction

    function automatic logic [INDEX-1:0] index_of(input logic [LINE_W-1:0] line);
        return line[INDEX-1:0];
    endfunction

endpackage

// File: rtl/fill_word_counter.sv
// Beat counter for a line refill.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   clr         - force count to 0 (new refill or return to idle)
//   inc         - advance to next word
//   cnt         - current word number 0..3
//   last        - high while cnt addresses the final word
module fill_word_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc,
    output logic [1:0] cnt,
    output logic       last
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= 2'd0;
        end else if (inc) begin
            cnt <= cnt + 2'd1;
        end
    end

    assign last = (cnt == 2'd3);

endmodule

// File: rtl/cache_line_fill.sv
// Refill engine for the cache data/tag arrays.
// On an accepted miss it fetches the 4-word line starting at word 0,
// assembles it, writes data + tag into the selected set for one cycle,
// then pulses fill_done.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   miss, miss_addr       - refill request and faulting byte address (sampled in IDLE)
//   busy                  - refill in progress (FETCH and WRITE)
//   mem_req, mem_addr     - memory word read request and word address
//   mem_ready, mem_rdata  - memory beat handshake and returned word
//   fill_we               - one-cycle array write strobe
//   fill_index, fill_tag  - set and tag written
//   fill_data             - assembled line, word k at bits [32k +: 32]
//   fill_done             - one-cycle completion pulse after fill_we
//
// state | meaning
// IDLE  | waiting for a miss
// FETCH | requesting words 0..3 from memory
// WRITE | fill_we asserted, line + tag written to arrays
// DONE  | fill_done pulse, new misses not accepted
module cache_line_fill
    import cache_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     miss,
    input  logic [ADDR_W-1:0]        miss_addr,
    output logic                     busy,
    output logic                     mem_req,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic                     mem_ready,
    input  logic [WORD_SIZE_BIT-1:0] mem_rdata,
    output logic                     fill_we,
    output logic [INDEX-1:0]         fill_index,
    output logic [TAG-1:0]           fill_tag,
    output logic [DATA_BLOCK-1:0]    fill_data,
    output logic                     fill_done
);

    fill_state_t       state_q, state_d;
    logic [LINE_W-1:0] line_addr;
    logic [1:0]        cnt;
    logic              last;
    logic              cnt_clr;
    logic              cnt_inc;
    logic              accept;
    logic              beat;

    // Fetch always starts at word 0, so the byte offset is never needed.
    logic unused_offset;
    assign unused_offset = ^miss_addr[OFFSET-1:0];

    fill_word_counter u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .cnt   (cnt),
        .last  (last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Captured only on accept, so tag/index hold steady through WRITE.
    always_ff @(posedge clk) begin
        if (reset) begin
            line_addr <= '0;
        end else if (accept) begin
            line_addr <= miss_addr[ADDR_W-1:OFFSET];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fill_data <= '0;
        end else if (beat) begin
            for (int k = 0; k < WORDS; k++) begin
                if (cnt == 2'(k)) begin
                    fill_data[k*WORD_SIZE_BIT +: WORD_SIZE_BIT] <= mem_rdata;
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        mem_req   = 1'b0;
        fill_we   = 1'b0;
        fill_done = 1'b0;
        accept    = 1'b0;
        beat      = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        case (state_q)
            IDLE: begin
                if (miss) begin
                    accept  = 1'b1;
                    cnt_clr = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                if (mem_ready) begin
                    beat = 1'b1;
                    // Hold at 3 on the final beat; the wrap happens on return to IDLE.
                    cnt_inc = !last;
                    if (last) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                busy    = 1'b1;
                fill_we = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                fill_done = 1'b1;
                cnt_clr   = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_addr   = {line_addr, cnt, 2'b00};
    assign fill_tag   = tag_of(line_addr);
    assign fill_index = index_of(line_addr);

endmodule

// File: tb/tb_cache_line_fill.sv
module tb_cache_line_fill;

    logic         clk = 1'b0;
    logic         reset;
    logic         miss;
    logic [31:0]  miss_addr;
    logic         busy;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_ready;
    logic [31:0]  mem_rdata;
    logic         fill_we;
    logic [7:0]   fill_index;
    logic [19:0]  fill_tag;
    logic [127:0] fill_data;
    logic         fill_done;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    cache_line_fill dut (
        .clk        (clk),
        .reset      (reset),
        .miss       (miss),
        .miss_addr  (miss_addr),
        .busy       (busy),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .fill_we    (fill_we),
        .fill_index (fill_index),
        .fill_tag   (fill_tag),
        .fill_data  (fill_data),
        .fill_done  (fill_done)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one refill. Memory answers beat k with base+k after 'waits' idle cycles.
    // inject_cyc: cycle to pulse a second miss (0x40); abort_beats: reset after that many beats.
    task automatic do_fill(input logic [31:0] addr, input int waits, input logic [31:0] base,
                           input int inject_cyc, input int abort_beats, input bit hold,
                           input int exp_we_cyc, input logic [19:0] exp_tag,
                           input logic [7:0] exp_idx, input logic [127:0] exp_data);
        int cyc;
        int beat;
        int wcnt;
        int we_cnt;
        int we_cyc;
        bit done;
        bit aborted;
        miss      = 1'b1;
        miss_addr = addr;
        tick();
        if (!hold) miss = 1'b0;
        cyc = 1; beat = 0; wcnt = 0; we_cnt = 0; we_cyc = -1; done = 0; aborted = 0;
        check("busy_after_accept", busy, 1);
        while (!done && cyc < 200) begin
            mem_ready = 1'b0;
            if (cyc == inject_cyc) begin
                miss = 1'b1; miss_addr = 32'h0000_0040;
            end else if (!hold) begin
                miss = 1'b0;
            end
            if (abort_beats >= 0 && beat == abort_beats) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                check("abort_fill_we", fill_we, 0);
                check("abort_busy", busy, 0);
                check("abort_mem_req", mem_req, 0);
                check("abort_fill_data", fill_data, 0);
                check("abort_fill_index", fill_index, 0);
                tick();
                check("abort_no_we_later", fill_we, 0);
                aborted = 1;
                done = 1;
            end else begin
                if (fill_we) begin
                    we_cnt++;
                    we_cyc = cyc;
                    check("we_mem_req_low", mem_req, 0);
                    check("we_fill_tag", fill_tag, exp_tag);
                    check("we_fill_index", fill_index, exp_idx);
                    check("we_fill_data", fill_data, exp_data);
                end
                if (fill_done) begin
                    check("done_cycle", cyc, we_cyc + 1);
                    check("done_busy_low", busy, 0);
                    done = 1;
                end else if (mem_req) begin
                    check("mem_addr", mem_addr, {addr[31:4], 2'(beat & 3), 2'b00});
                    if (wcnt == waits) begin
                        mem_ready = 1'b1;
                        mem_rdata = base + 32'(beat);
                        beat++;
                        wcnt = 0;
                    end else begin
                        mem_rdata = 32'hDEAD_BEEF;
                        wcnt++;
                    end
                end
                if (!done) begin
                    tick();
                    cyc++;
                end
            end
        end
        mem_ready = 1'b0;
        if (aborted) begin
            check("abort_we_count", we_cnt, 0);
        end else begin
            check("fill_finished", done, 1);
            check("we_count", we_cnt, 1);
            check("we_cycle", we_cyc, exp_we_cyc);
            check("beats_taken", beat, 4);
        end
    endtask

    localparam logic [127:0] LINE_A = 128'h0000_00A3_0000_00A2_0000_00A1_0000_00A0;

    initial begin
        reset     = 1'b1;
        miss      = 1'b1;
        miss_addr = 32'h1234_5678;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;

        // reset held 2 cycles with miss high
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_busy", busy, 0);
            check("rst_mem_req", mem_req, 0);
            check("rst_fill_we", fill_we, 0);
            check("rst_fill_done", fill_done, 0);
        end
        check("rst_fill_data", fill_data, 0);
        check("rst_fill_tag", fill_tag, 0);
        reset = 1'b0;
        miss  = 1'b0;
        tick();
        check("post_rst_idle", busy, 0);

        // zero-wait fill
        do_fill(32'h1234_5678, 0, 32'hA0, -1, -1, 0, 5, 20'h12345, 8'h67, LINE_A);
        tick();

        // three wait cycles before each beat
        do_fill(32'h1234_5678, 3, 32'hA0, -1, -1, 0, 17, 20'h12345, 8'h67, LINE_A);
        tick();

        // second miss pulsed during FETCH is dropped
        do_fill(32'h1234_5678, 0, 32'hA0, 2, -1, 0, 5, 20'h12345, 8'h67, LINE_A);
        tick();
        check("miss_busy_not_queued", busy, 0);
        tick();
        check("miss_busy_not_queued2", busy, 0);
        check("miss_no_extra_req", mem_req, 0);

        // reset after beat 2, then refetch from word 0
        do_fill(32'h1234_5678, 0, 32'hA0, -1, 2, 0, 0, 20'h0, 8'h0, 128'h0);
        do_fill(32'h1234_5678, 0, 32'hA0, -1, -1, 0, 5, 20'h12345, 8'h67, LINE_A);
        tick();

        // back-to-back with miss held high
        do_fill(32'hABCD_E010, 0, 32'h100, -1, -1, 1, 5, 20'hABCDE, 8'h01,
                128'h0000_0103_0000_0102_0000_0101_0000_0100);
        miss_addr = 32'h0000_0040;
        tick();
        check("b2b_idle_gap_busy", busy, 0);
        do_fill(32'h0000_0040, 0, 32'h200, -1, -1, 1, 5, 20'h00000, 8'h04,
                128'h0000_0203_0000_0202_0000_0201_0000_0200);
        miss = 1'b0;
        tick();
        tick();
        check("b2b_end_idle", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
